// File: rtl/freq_meas_seq.sv
// Measurement sequencer for the equal-precision frequency counter: drives the preset gate, times the
// real gate in sys_clk cycles, collects the captured test count and divides to produce freq_hz.
module freq_meas_seq #(
  parameter logic [31:0] CLK_HZ      = 32'd48_000_000,
  parameter logic [27:0] PREP_CYC    = 28'd12_000_000,
  parameter logic [27:0] GATE_CYC    = 28'd48_000_000,
  parameter logic [27:0] TIMEOUT_CYC = 28'd24_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        cont_mode,
  input  logic        abort,
  output logic        gate_s,
  input  logic        gate_a,
  input  logic [31:0] cnt_test,
  input  logic        cnt_tgl,
  output logic        busy,
  output logic [31:0] freq_hz,
  output logic        freq_valid,
  output logic        meas_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_GATE  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DIV   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state_reg, state_next;
  logic [27:0] timer_reg;
  logic [31:0] cnt_std_reg;
  logic [63:0] num_reg;
  logic [31:0] rem_reg;
  logic [5:0]  div_cnt_reg;
  logic [31:0] freq_hz_reg;
  logic        meas_err_reg;

  logic gate_a_meta_reg, gate_a_s;
  logic tgl_meta_reg, tgl_s, tgl_s_d;
  logic tgl_edge;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gate_a_meta_reg <= 1'b0;
      gate_a_s        <= 1'b0;
      tgl_meta_reg    <= 1'b0;
      tgl_s           <= 1'b0;
      tgl_s_d         <= 1'b0;
    end else begin
      gate_a_meta_reg <= gate_a;
      gate_a_s        <= gate_a_meta_reg;
      tgl_meta_reg    <= cnt_tgl;
      tgl_s           <= tgl_meta_reg;
      tgl_s_d         <= tgl_s;
    end
  end

  assign tgl_edge = tgl_s ^ tgl_s_d;

  logic timeout_hit;
  assign timeout_hit = (timer_reg == TIMEOUT_CYC - 28'd1);

  // One restoring-division step: the remainder stays below the divisor, so the
  // 32-bit modular difference is exact whenever the subtraction is taken.
  logic [32:0] rem_shift;
  logic        q_bit;
  logic [31:0] rem_step;
  logic [63:0] quot_step;
  assign rem_shift = {rem_reg, num_reg[63]};
  assign q_bit     = (rem_shift >= {1'b0, cnt_std_reg});
  assign rem_step  = q_bit ? (rem_shift[31:0] - cnt_std_reg) : rem_shift[31:0];
  assign quot_step = {num_reg[62:0], q_bit};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_PREP;
      S_PREP:  if (timer_reg == PREP_CYC - 28'd1) state_next = S_GATE;
      S_GATE:  if (timer_reg == GATE_CYC - 28'd1) state_next = S_DRAIN;
      S_DRAIN: begin
        if (!gate_a_s)        state_next = S_WAIT;
        else if (timeout_hit) state_next = S_DONE;
      end
      S_WAIT: begin
        if (tgl_edge)         state_next = (cnt_std_reg == 32'd0) ? S_DONE : S_DIV;
        else if (timeout_hit) state_next = S_DONE;
      end
      S_DIV:   if (div_cnt_reg == 6'd63) state_next = S_DONE;
      S_DONE:  state_next = cont_mode ? S_PREP : S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      cnt_std_reg  <= '0;
      num_reg      <= '0;
      rem_reg      <= '0;
      div_cnt_reg  <= '0;
      freq_hz_reg  <= '0;
      meas_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= (state_next != state_reg) ? 28'd0 : timer_reg + 28'd1;

      if (state_next == S_PREP && state_reg != S_PREP)
        cnt_std_reg <= '0;
      else if ((state_reg == S_GATE || state_reg == S_DRAIN) && gate_a_s && cnt_std_reg != 32'hFFFF_FFFF)
        cnt_std_reg <= cnt_std_reg + 32'd1;

      if (state_reg == S_WAIT && state_next == S_DIV) begin
        num_reg     <= {32'd0, cnt_test} * {32'd0, CLK_HZ};
        rem_reg     <= '0;
        div_cnt_reg <= '0;
      end else if (state_reg == S_DIV) begin
        num_reg     <= quot_step;
        rem_reg     <= rem_step;
        div_cnt_reg <= div_cnt_reg + 6'd1;
      end

      // Results land together with the DONE entry so they are valid on the freq_valid cycle.
      if (state_next == S_DONE) begin
        if (state_reg == S_DIV) begin
          freq_hz_reg  <= (quot_step[63:32] != 32'd0) ? 32'hFFFF_FFFF : quot_step[31:0];
          meas_err_reg <= 1'b0;
        end else begin
          freq_hz_reg  <= '0;
          meas_err_reg <= 1'b1;
        end
      end
    end
  end

  assign gate_s     = (state_reg == S_GATE);
  assign busy       = (state_reg != S_IDLE);
  assign freq_valid = (state_reg == S_DONE);
  assign freq_hz    = freq_hz_reg;
  assign meas_err   = meas_err_reg;

endmodule

// File: tb/tb_freq_meas_seq.sv
// Self-checking bench for freq_meas_seq: randomized gate widths and counts against an
// arithmetic reference of freq_hz = floor(cnt_test*CLK_HZ/cnt_std) with saturation.
module tb_freq_meas_seq;

  localparam logic [31:0] CLK_HZ = 32'd50_000_000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont_mode = 1'b0;
  logic        abort = 1'b0;
  logic        gate_a = 1'b0;
  logic [31:0] cnt_test = 32'd0;
  logic        cnt_tgl = 1'b0;
  logic        gate_s, busy, freq_valid, meas_err;
  logic [31:0] freq_hz;

  int n_checks = 0;
  int n_fail = 0;
  int gs_cnt = 0;
  int fv_cnt = 0;
  logic [31:0] last_freq = 32'd0;
  logic        last_err = 1'b0;

  freq_meas_seq #(
    .CLK_HZ(CLK_HZ), .PREP_CYC(28'd100), .GATE_CYC(28'd1000), .TIMEOUT_CYC(28'd500)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .cont_mode(cont_mode),
    .abort(abort), .gate_s(gate_s), .gate_a(gate_a), .cnt_test(cnt_test), .cnt_tgl(cnt_tgl),
    .busy(busy), .freq_hz(freq_hz), .freq_valid(freq_valid), .meas_err(meas_err)
  );

  always #10 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (gate_s) gs_cnt++;
    if (freq_valid) fv_cnt++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] ref_freq(input logic [31:0] ct, input int n);
    logic [63:0] q;
    q = ({32'd0, ct} * {32'd0, CLK_HZ}) / 64'(unsigned'(n));
    return (q[63:32] != 32'd0) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  // One measurement: gate_a is high for exactly n_hi sys_clk samples, so cnt_std must equal n_hi.
  task automatic run_meas(input bit pulse_start, input bit cont_next, input int n_hi, input int dly,
                          input logic [31:0] ct, input bit stale, input bit start_in_div,
                          input bit rst_in_div);
    int k;
    int gs0;
    int fv0;
    logic [31:0] exp_f;
    logic exp_e;
    int exp_lat;
    gs0 = gs_cnt;
    fv0 = fv_cnt;
    if (pulse_start) begin
      @(negedge sys_clk); start = 1'b1;
      @(negedge sys_clk); start = 1'b0;
    end
    k = 0;
    while (gate_s !== 1'b1 && k < 3000) begin @(negedge sys_clk); k++; end
    if (gate_s !== 1'b1) begin
      check_val("gate_rise", gate_s, 1);
      return;
    end
    if (pulse_start) check_val("prep_len", k, 100);
    cont_mode = cont_next;
    repeat (dly) @(negedge sys_clk);
    if (stale) begin
      cnt_test = $urandom;
      cnt_tgl = ~cnt_tgl;
    end
    if (n_hi > 0) begin
      gate_a = 1'b1;
      repeat (n_hi) @(negedge sys_clk);
      gate_a = 1'b0;
    end
    k = 0;
    while ((gate_s || gate_a) && k < 3000) begin @(negedge sys_clk); k++; end
    repeat (5) @(negedge sys_clk);
    cnt_test = ct;
    cnt_tgl = ~cnt_tgl;
    exp_e = (n_hi == 0);
    exp_f = exp_e ? 32'd0 : ref_freq(ct, n_hi);
    exp_lat = exp_e ? 3 : 67;
    k = 0;
    while (k < 200) begin
      @(posedge sys_clk); #1; k++;
      if (freq_valid) break;
      start = (start_in_div && k == 20);
      if (rst_in_div && k == 30) begin
        sys_rst_n = 1'b0;
        #2;
        check_val("reset_mid_div", {gate_s, busy, freq_valid, meas_err, freq_hz}, 0);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        last_freq = 32'd0;
        last_err = 1'b0;
        return;
      end
    end
    start = 1'b0;
    check_val("latency", k, exp_lat);
    check_val("freq_hz", freq_hz, exp_f);
    check_val("meas_err", meas_err, exp_e);
    last_freq = exp_f;
    last_err = exp_e;
    check_val("gate_len", gs_cnt - gs0, 1000);
    @(posedge sys_clk); #1;
    check_val("busy_after_done", busy, cont_mode);
    @(posedge sys_clk); #1;
    check_val("valid_pulses", fv_cnt - fv0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int fv0;
    int n;
    logic [31:0] ct;

    repeat (3) @(negedge sys_clk);
    check_val("reset_outputs", {gate_s, busy, freq_valid, meas_err, freq_hz}, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 10 MHz test clock over a 1000-cycle gate
    run_meas(1, 0, 1000, 3, 32'd200, 0, 0, 0);

    // continuous mode at 1 MHz, second run stops the chain
    run_meas(1, 1, 1000, 2, 32'd20, 0, 0, 0);
    run_meas(0, 0, 999, 5, 32'd20, 0, 0, 0);

    // stopped test clock: WAIT_CNT timeout
    fv0 = fv_cnt;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    k = 0;
    while (gate_s !== 1'b1 && k < 3000) begin @(negedge sys_clk); k++; end
    k = 0;
    while (gate_s && k < 3000) begin @(posedge sys_clk); #1; k++; end
    k = 0;
    while (!freq_valid && k < 1000) begin @(posedge sys_clk); #1; k++; end
    check_val("timeout_latency", k, 501);
    check_val("timeout_freq", freq_hz, 0);
    check_val("timeout_err", meas_err, 1);
    @(posedge sys_clk); #1;
    check_val("timeout_pulses", fv_cnt - fv0, 1);
    last_freq = 32'd0;
    last_err = 1'b1;

    // cnt_std==0 with a real toggle: error without any DIV cycles
    run_meas(1, 0, 0, 4, 32'd1234, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 1400);
      ct = (r % 2 == 1) ? $urandom : 32'($urandom_range(0, 5000));
      run_meas(1, 0, n, $urandom_range(0, 20), ct, 1'($urandom_range(0, 1)), 0, 0);
    end

    // abort mid-GATE
    fv0 = fv_cnt;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    k = 0;
    while (gate_s !== 1'b1 && k < 3000) begin @(negedge sys_clk); k++; end
    repeat (300) @(negedge sys_clk);
    abort = 1'b1;
    @(posedge sys_clk); #1;
    check_val("abort_gate_s", gate_s, 0);
    check_val("abort_busy", busy, 0);
    @(negedge sys_clk); abort = 1'b0;
    repeat (200) @(negedge sys_clk);
    check_val("abort_no_valid", fv_cnt - fv0, 0);
    check_val("abort_freq_held", freq_hz, last_freq);
    check_val("abort_err_held", meas_err, last_err);

    // abort beats start in the same cycle
    @(negedge sys_clk); start = 1'b1; abort = 1'b1;
    @(negedge sys_clk); start = 1'b0; abort = 1'b0;
    check_val("abort_over_start", busy, 0);

    // saturation, with a start pulse during DIV that must be ignored
    run_meas(1, 0, 1, 7, 32'hFFFF_FFFF, 0, 1, 0);
    repeat (5) @(negedge sys_clk);
    check_val("no_retrigger", busy, 0);

    // asynchronous reset in the middle of DIV
    run_meas(1, 0, 800, 1, 32'd4321, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
